// File: rtl/am_sample_scheduler.sv
// am_sample_scheduler: pulls stream samples and issues exactly one per PWM frame of clks_per_pwm_step*pwm_steps clocks.
module am_sample_scheduler #(
  parameter int DATA_W   = 8,
  parameter int MIDSCALE = 128,
  parameter int UCNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [7:0]        clks_per_pwm_step,
  input  logic [7:0]        pwm_steps,
  input  logic              underrun_mode,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] sample,
  output logic              new_sample,
  output logic [UCNT_W-1:0] underrun_count,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, PRIME, ISSUE, RUN} state_t;
  localparam logic [DATA_W-1:0] MID = DATA_W'(MIDSCALE);
  state_t state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d, sample_q, sample_d;
  logic hold_full_q, hold_full_d, new_q, new_d, xfer;
  logic [15:0] cnt_q, cnt_d, n;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;
  assign n = 16'(clks_per_pwm_step) * 16'(pwm_steps);
  assign s_ready = state_q == PRIME || (state_q == RUN && !hold_full_q);
  assign xfer = s_valid && s_ready;
  assign busy = state_q != IDLE;
  assign sample = sample_q;
  assign new_sample = new_q;
  assign underrun_count = ucnt_q;
  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    hold_full_d = hold_full_q;
    sample_d = sample_q;
    new_d = 1'b0;
    cnt_d = cnt_q;
    ucnt_d = ucnt_q;
    if (!enable) begin
      state_d = IDLE;
      hold_full_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: state_d = n != 16'd0 ? PRIME : IDLE;
        PRIME: if (xfer) begin
          hold_d = s_data;
          hold_full_d = 1'b1;
          state_d = ISSUE;
        end
        ISSUE: begin
          new_d = 1'b1;
          sample_d = hold_q;
          hold_full_d = 1'b0;
          cnt_d = n - 16'd1;
          state_d = n == 16'd0 ? IDLE : RUN;
        end
        RUN: if (cnt_q == 16'd0) begin
          // Frame boundary: the frame length is re-read here so config changes land only on issues
          new_d = 1'b1;
          cnt_d = n - 16'd1;
          state_d = n == 16'd0 ? IDLE : RUN;
          if (hold_full_q) begin
            sample_d = hold_q;
            hold_full_d = 1'b0;
          end else if (xfer) begin
            sample_d = s_data;
          end else begin
            sample_d = underrun_mode ? MID : sample_q;
            ucnt_d = &ucnt_q ? ucnt_q : ucnt_q + UCNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
          if (xfer) begin
            hold_d = s_data;
            hold_full_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q <= '0;
      hold_full_q <= 1'b0;
      sample_q <= MID;
      new_q <= 1'b0;
      cnt_q <= '0;
      ucnt_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      hold_full_q <= hold_full_d;
      sample_q <= sample_d;
      new_q <= new_d;
      cnt_q <= cnt_d;
      ucnt_q <= ucnt_d;
    end
  end
endmodule

// File: tb/tb_am_sample_scheduler.sv
// tb_am_sample_scheduler: directed checks of pacing, underrun policies, bypass, zero/one-clock frames, enable drop and reset.
module tb_am_sample_scheduler;
  logic clk, rst, enable, underrun_mode, s_valid, s_ready, new_sample, busy, auto_inc;
  logic [7:0] cps, steps, s_data, sample;
  logic [15:0] ucnt;
  logic [7:0] qs[$];
  int qc[$];
  int cyc, total, bad;
  am_sample_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .clks_per_pwm_step(cps), .pwm_steps(steps),
    .underrun_mode(underrun_mode), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .sample(sample), .new_sample(new_sample), .underrun_count(ucnt), .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(int n);
    logic x;
    for (int i = 0; i < n; i++) begin
      x = s_valid && s_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (x && auto_inc) s_data = s_data + 8'd1;
      if (new_sample) begin
        qs.push_back(sample);
        qc.push_back(cyc);
      end
    end
  endtask
  task automatic restart();
    enable = 1'b0;
    tick(1);
    qs.delete();
    qc.delete();
    cyc = 0;
  endtask
  initial begin
    total = 0; bad = 0; cyc = 0; auto_inc = 1'b0;
    rst = 1'b1; enable = 1'b0; underrun_mode = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    cps = 8'd2; steps = 8'd10;
    #12;
    chk("rst_sample", sample, 8'd128);
    chk("rst_new", new_sample, 1'b0);
    chk("rst_ready", s_ready, 1'b0);
    chk("rst_ucnt", ucnt, 16'd0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    restart();
    s_valid = 1'b1; s_data = 8'h10; auto_inc = 1'b1; enable = 1'b1;
    tick(65);
    chk("norm_count", qs.size(), 4);
    chk("norm_first", qc[0], 3);
    chk("norm_gap1", qc[1] - qc[0], 20);
    chk("norm_gap3", qc[3] - qc[2], 20);
    chk("norm_s0", qs[0], 8'h10);
    chk("norm_s1", qs[1], 8'h11);
    chk("norm_s3", qs[3], 8'h13);
    chk("norm_ucnt", ucnt, 16'd0);
    restart();
    underrun_mode = 1'b0; s_data = 8'h80; auto_inc = 1'b0; s_valid = 1'b1; enable = 1'b1;
    tick(2);
    s_valid = 1'b0;
    tick(61);
    chk("rep_count", qs.size(), 4);
    chk("rep_s1", qs[1], 8'h80);
    chk("rep_s3", qs[3], 8'h80);
    chk("rep_ucnt", ucnt, 16'd3);
    restart();
    underrun_mode = 1'b1; s_data = 8'h0A; s_valid = 1'b1; enable = 1'b1;
    tick(2);
    s_valid = 1'b0;
    tick(21);
    chk("mid_count", qs.size(), 2);
    chk("mid_s0", qs[0], 8'h0A);
    chk("mid_s1", qs[1], 8'd128);
    chk("mid_ucnt", ucnt, 16'd4);
    restart();
    underrun_mode = 1'b0; cps = 8'd2; steps = 8'd2; s_data = 8'h33; s_valid = 1'b1; enable = 1'b1;
    tick(2);
    s_valid = 1'b0;
    tick(4);
    chk("byp_ready", s_ready, 1'b1);
    s_data = 8'h55; s_valid = 1'b1;
    tick(1);
    s_valid = 1'b0;
    chk("byp_new", new_sample, 1'b1);
    chk("byp_sample", sample, 8'h55);
    chk("byp_gap", qc[1] - qc[0], 4);
    chk("byp_ucnt", ucnt, 16'd4);
    restart();
    steps = 8'd0; cps = 8'd1; enable = 1'b1;
    tick(3);
    chk("zero_busy", busy, 1'b0);
    chk("zero_pulses", qs.size(), 0);
    restart();
    steps = 8'd1; s_data = 8'h20; s_valid = 1'b1; auto_inc = 1'b1; enable = 1'b1;
    tick(10);
    chk("one_count", qs.size(), 8);
    chk("one_gap", qc[7] - qc[6], 1);
    chk("one_s7", qs[7], 8'h27);
    chk("one_ucnt", ucnt, 16'd4);
    restart();
    cps = 8'd2; steps = 8'd10; s_data = 8'h40; s_valid = 1'b1; enable = 1'b1;
    tick(3);
    chk("drop_first", qs[0], 8'h40);
    tick(7);
    enable = 1'b0;
    tick(1);
    chk("drop_busy", busy, 1'b0);
    chk("drop_ready", s_ready, 1'b0);
    tick(30);
    chk("drop_pulses", qs.size(), 1);
    chk("drop_sample", sample, 8'h40);
    chk("drop_ucnt", ucnt, 16'd4);
    enable = 1'b1;
    tick(10);
    rst = 1'b1;
    #1;
    chk("mrst_sample", sample, 8'd128);
    chk("mrst_ucnt", ucnt, 16'd0);
    chk("mrst_ready", s_ready, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_new", new_sample, 1'b0);
    #5;
    rst = 1'b0;
    qs.delete();
    qc.delete();
    tick(2);
    chk("mrst_nopulse", qs.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
